mux_rr_arbiter: RTL and testbench
=================================

# mux_rr_arbiter

Round-robin arbiter and sequencer for the 4:1 data mux. Four requesters compete for the single mux output. The block grants one requester at a time, drives the mux select lines `s1`/`s0` to match, and registers the selected data onto `y` with a valid flag. A per-grant hold limit keeps any one requester from starving the others.

## Interface
- `WIDTH`, default 1: data width of each mux input and of `y`.
- `MAX_HOLD`, default 4: maximum consecutive grant cycles while another requester is waiting. Legal range is 1..15.
- `clk`  input  1: single clock; all state changes on the rising edge.
- `rst_n`  input  1: reset, asynchronous and active-low.
- `req`  input  4: request vector; `req[n]` belongs to input `in`.
- `i0`, `i1`, `i2`, `i3`  input  WIDTH each: mux data inputs.
- `gnt`  output  4: one-hot grant, or all-zero when idle; registered.
- `s1`, `s0`  output  1 each: mux select, equal to the binary index of the granted input; registered.
- `y`  output  WIDTH: registered mux output.
- `y_valid`  output  1: `y` holds data from a granted requester.

## Operation
- State machine with two states.
  - IDLE: `gnt` is 0.
  - GRANT: `gnt` is one-hot; `owner` is the granted index.
- Priority pointer `ptr` (2 bits) sets the search start. Search order is `ptr`, `ptr+1`, `ptr+2`, `ptr+3`, all mod 4. The first set `req` bit in that order wins.
- Transitions out of IDLE:
  - Any `req` bit set: go to GRANT, grant the winner, `hold_cnt` = 1.
  - No request: stay in IDLE.
- Release condition, evaluated in GRANT: `req[owner]` = 0, OR (`hold_cnt` == `MAX_HOLD` AND any other `req` bit is set).
- On release:
  - `ptr` = `owner`+1 (mod 4).
  - Re-arbitrate in the same cycle from the new `ptr`, with `owner` excluded only when its `req` is low.
  - If a winner exists, grant it directly with no idle bubble, and set `hold_cnt` = 1.
  - Otherwise go to IDLE, `gnt` = 0.
- No release while in GRANT:
  - Keep the current grant.
  - `hold_cnt` increments, saturating at `MAX_HOLD`.
  - A sole requester keeps its grant indefinitely.
- `{s1,s0}` is updated together with `gnt`. It holds its last value in IDLE.
- Data path:
  - `y` <= `i[{s1,s0}]` whenever `gnt` != 0; otherwise `y` holds.
  - `y_valid` <= (`gnt` != 0).
- Hold-expiry case: when the hold limit fires and the only other requester is the owner itself, it is not a release, since "another request" excludes the owner.

## Timing
- Reset (asynchronous, takes effect immediately, including mid-grant):
  - Outputs: `gnt`=0, `s1`=`s0`=0, `y`=0, `y_valid`=0.
  - Internal: `ptr`=0, `hold_cnt`=0, state IDLE.
- Leaving reset: the first rising edge with `rst_n`=1 performs normal arbitration.
- Request to grant: `req` sampled high at edge k, so `gnt`/`s1`/`s0` are valid after edge k (1 cycle).
- Grant to data: `y`/`y_valid` reflect the selected input sampled at edge k+1 (1 further cycle). Total request-to-data latency is 2 cycles.
- Requester drop: `req[owner]` dropping at edge k means the grant moves or clears at edge k. `y_valid` falls at edge k+1 if the block goes IDLE.
- Back-to-back grants to different owners: `gnt` switches in one edge, and `y_valid` stays high continuously.
- Simultaneous requests: the pointer order resolves them. After reset, `req`=4'b1111 grants input 0 first.
- Pointer wrap-around: owner 3 releases, so `ptr` = 0.

## Test plan
- **Reset values:** drive `rst_n`=0 mid-grant of input 2 with `req`=4'b0100. Required: immediately `gnt`=0, `s1s0`=00, `y`=0, `y_valid`=0. After release, the first grant with `req`=4'b1111 goes to input 0.
- **Single requester:** `req`=4'b0010, `i1`=1, others 0, held for 10 cycles. Required: `gnt`=4'b0010 and `s1s0`=01 after 1 cycle; `y`=1 and `y_valid`=1 after 2 cycles. The grant never drops (hold saturates).
- **Round-robin fairness:** `req`=4'b1111 held, `MAX_HOLD`=4. Required grant sequence is 0,1,2,3,0, 4 cycles each, with no `gnt`=0 cycle between them. `s1s0` tracks 00,01,10,11.
- **Early release:** input 0 granted; at its 2nd cycle `req` changes to 4'b1000. Required: at the next edge `gnt`=4'b1000, `s1s0`=11, `hold_cnt` restarts at 1.
- **Go idle:** `req` goes from 4'b0100 to 4'b0000. Required: `gnt`=0 next edge, `y_valid`=0 one edge later, `y` holds its last value, `s1s0` stays 10.
- **Mux routing:** for each granted index n, drive a walking one on `i0`..`i3` as in the mux bench. Required: `y` equals `in` for every n.

Source files
------------

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter/sequencer for a 4:1 data mux: grants one requester,
// drives the select lines, and registers the selected data with a valid flag.
module mux_rr_arbiter #(
  parameter int WIDTH    = 1,
  parameter int MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       req,
  input  logic [WIDTH-1:0] i0,
  input  logic [WIDTH-1:0] i1,
  input  logic [WIDTH-1:0] i2,
  input  logic [WIDTH-1:0] i3,
  output logic [3:0]       gnt,
  output logic             s1,
  output logic             s0,
  output logic [WIDTH-1:0] y,
  output logic             y_valid
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [3:0] HOLD_MAX = 4'(MAX_HOLD);

  state_t                  state, state_nxt;
  logic [1:0]              ptr, ptr_nxt;
  logic [1:0]              owner, owner_nxt;
  logic [3:0]              hold_cnt, hold_nxt;
  logic [3:0]              gnt_nxt;
  logic [3:0]              others;
  logic [2:0]              win, win_rel;
  logic                    rel;
  logic [3:0][WIDTH-1:0]   din;

  assign din   = {i3, i2, i1, i0};
  assign owner = {s1, s0};

  // {found, index} of the first set request searching p, p+1, p+2, p+3.
  function automatic logic [2:0] pick(input logic [3:0] r, input logic [1:0] p);
    logic [2:0] res;
    logic [1:0] idx;
    res = '0;
    for (int k = 3; k >= 0; k--) begin
      idx = p + 2'(k);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    owner_nxt = owner;
    hold_nxt  = hold_cnt;
    others    = req & ~(4'b0001 << owner);
    win       = pick(req, ptr);
    win_rel   = pick(req, owner + 2'd1);
    rel       = !req[owner] || ((hold_cnt == HOLD_MAX) && (|others));
    case (state)
      IDLE: begin
        if (win[2]) begin
          state_nxt = GRANT;
          owner_nxt = win[1:0];
          hold_nxt  = 4'd1;
        end
      end
      GRANT: begin
        if (rel) begin
          ptr_nxt = owner + 2'd1;
          // Owner searches last from the new pointer, so it only wins again
          // when nobody else is asking.
          if (win_rel[2]) begin
            owner_nxt = win_rel[1:0];
            hold_nxt  = 4'd1;
          end else begin
            state_nxt = IDLE;
          end
        end else if (hold_cnt != HOLD_MAX) begin
          hold_nxt = hold_cnt + 4'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    gnt_nxt = (state_nxt == GRANT) ? (4'b0001 << owner_nxt) : 4'b0000;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= 2'd0;
      hold_cnt <= 4'd0;
      gnt      <= 4'd0;
      s1       <= 1'b0;
      s0       <= 1'b0;
      y        <= '0;
      y_valid  <= 1'b0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      hold_cnt <= hold_nxt;
      gnt      <= gnt_nxt;
      {s1, s0} <= owner_nxt;
      if (|gnt) y <= din[owner];
      y_valid  <= |gnt;
    end
  end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed + random bench for mux_rr_arbiter against a behavioural model.
module tb_mux_rr_arbiter;
  localparam int W    = 4;
  localparam int MAXH = 4;

  logic         clk, rst_n;
  logic [3:0]   req;
  logic [W-1:0] i0, i1, i2, i3;
  logic [3:0]   gnt;
  logic         s1, s0;
  logic [W-1:0] y;
  logic         y_valid;

  mux_rr_arbiter #(.WIDTH(W), .MAX_HOLD(MAXH)) dut (
    .clk(clk), .rst_n(rst_n), .req(req),
    .i0(i0), .i1(i1), .i2(i2), .i3(i3),
    .gnt(gnt), .s1(s1), .s0(s0), .y(y), .y_valid(y_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // behavioural model state
  int           m_ptr, m_own, m_hold;
  bit           m_busy;
  logic [3:0]   m_gnt;
  logic [1:0]   m_sel;
  logic [W-1:0] m_y;
  logic         m_yv;

  function automatic int find(input logic [3:0] r, input int p);
    for (int k = 0; k < 4; k++)
      if (r[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_own = 0; m_hold = 0; m_busy = 0;
    m_gnt = 4'd0; m_sel = 2'd0; m_y = '0; m_yv = 1'b0;
  endtask

  task automatic model_step(input logic [3:0] r, input logic [W-1:0] d0, d1, d2, d3);
    logic [W-1:0] d [4];
    int w;
    d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
    if (m_gnt != 0) m_y = d[m_sel];
    m_yv = (m_gnt != 0);
    if (!m_busy) begin
      w = find(r, m_ptr);
      if (w >= 0) begin m_busy = 1; m_own = w; m_hold = 1; end
    end else if (!r[m_own] || (m_hold == MAXH && (r & ~(4'b0001 << m_own)) != 0)) begin
      m_ptr = (m_own + 1) % 4;
      w = find(r, m_ptr);
      if (w >= 0) begin m_own = w; m_hold = 1; end
      else m_busy = 0;
    end else if (m_hold < MAXH) begin
      m_hold++;
    end
    m_gnt = m_busy ? (4'b0001 << m_own) : 4'b0000;
    if (m_busy) m_sel = 2'(m_own);
  endtask

  task automatic check(input string tag);
    n_vec++;
    assert (gnt === m_gnt) else begin
      n_err++; $error("FAIL %s gnt got %b want %b", tag, gnt, m_gnt);
    end
    assert ({s1, s0} === m_sel) else begin
      n_err++; $error("FAIL %s sel got %b want %b", tag, {s1, s0}, m_sel);
    end
    assert (y === m_y) else begin
      n_err++; $error("FAIL %s y got %h want %h", tag, y, m_y);
    end
    assert (y_valid === m_yv) else begin
      n_err++; $error("FAIL %s y_valid got %b want %b", tag, y_valid, m_yv);
    end
  endtask

  task automatic cyc(input logic [3:0] r, input logic [W-1:0] d0, d1, d2, d3, input string tag);
    req = r; i0 = d0; i1 = d1; i2 = d2; i3 = d3;
    @(posedge clk);
    model_step(r, d0, d1, d2, d3);
    #1 check(tag);
  endtask

  initial begin
    rst_n = 1'b0; req = 4'd0; i0 = '0; i1 = '0; i2 = '0; i3 = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 check("reset");
    @(negedge clk) rst_n = 1'b1;

    // grant input 2, then reset asynchronously mid-grant
    repeat (3) cyc(4'b0100, 4'h1, 4'h2, 4'h4, 4'h8, "pre_reset");
    #2 rst_n = 1'b0;
    #1 model_reset(); check("async_reset");
    @(negedge clk) rst_n = 1'b1;
    cyc(4'b1111, 4'h0, 4'h0, 4'h0, 4'h0, "first_after_reset");
    n_vec++;
    assert (gnt === 4'b0001) else begin
      n_err++; $error("FAIL first_grant got %b want 0001", gnt);
    end

    // single requester holds indefinitely
    cyc(4'b0000, 4'h0, 4'h0, 4'h0, 4'h0, "idle_gap");
    cyc(4'b0000, 4'h0, 4'h0, 4'h0, 4'h0, "idle_gap");
    repeat (10) cyc(4'b0010, 4'h0, 4'h1, 4'h0, 4'h0, "single");

    // round-robin fairness with everyone requesting
    repeat (20) cyc(4'b1111, 4'h3, 4'h5, 4'h9, 4'hC, "fair");

    // early release to input 3
    cyc(4'b0000, 4'h0, 4'h0, 4'h0, 4'h0, "idle_gap");
    repeat (2) cyc(4'b0001, 4'hA, 4'h0, 4'h0, 4'hB, "early_own0");
    repeat (3) cyc(4'b1000, 4'hA, 4'h0, 4'h0, 4'hB, "early_to3");

    // go idle from input 2
    repeat (3) cyc(4'b0100, 4'h0, 4'h0, 4'h6, 4'h0, "pre_idle");
    repeat (3) cyc(4'b0000, 4'hF, 4'hF, 4'hF, 4'hF, "go_idle");

    // mux routing: walking one per input, each index granted in turn
    for (int n = 0; n < 4; n++) begin
      repeat (3) cyc(4'b0001 << n, 4'h1, 4'h2, 4'h4, 4'h8, "route");
      cyc(4'b0000, 4'h1, 4'h2, 4'h4, 4'h8, "route_gap");
    end

    // random traffic with sticky requests
    for (int t = 0; t < 400; t++) begin
      logic [3:0] r;
      r = 4'($urandom);
      if ($urandom_range(0, 3) != 0) r = req ^ (4'b0001 << $urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) r = 4'd0;
      cyc(r, W'($urandom), W'($urandom), W'($urandom), W'($urandom), "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
endmodule
